// File: rtl/vga_pkg.sv
// Shared types and default timing constants for the VGA pixel pipeline.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

    // The timing generator's N_MIXER_PIPE_STAGES must equal this value.
    localparam int MIXER_PIPE_STAGES = 2;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_t;

    function automatic rgb_t background(input logic [3:0] hx, input logic [3:0] vy);
        rgb_t c;
        c.r = hx;
        c.g = vy;
        c.b = hx ^ vy;
        return c;
    endfunction

endpackage

// File: rtl/vga_sprite_mixer_if.sv
// Pixel-stage bundle between the timing generator (master) and the sprite mixer (slave).
interface vga_sprite_mixer_if #(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10
);

    logic                  pixel_en;
    logic                  hsync_in;
    logic                  vsync_in;
    logic                  display_on_in;
    logic [HPOS_WIDTH-1:0] hpos;
    logic [VPOS_WIDTH-1:0] vpos;
    logic [2:0]            speed;
    logic [11:0]           sprite_rgb;
    logic                  hsync;
    logic                  vsync;
    logic [11:0]           rgb;
    logic                  frame_tick;

    modport master (
        output pixel_en, hsync_in, vsync_in, display_on_in, hpos, vpos, speed, sprite_rgb,
        input  hsync, vsync, rgb, frame_tick
    );

    modport slave (
        input  pixel_en, hsync_in, vsync_in, display_on_in, hpos, vpos, speed, sprite_rgb,
        output hsync, vsync, rgb, frame_tick
    );

endinterface

// File: rtl/vga_sprite_mixer_motion.sv
// Sprite position keeper: detects the vsync falling edge and bounces the sprite
// off the visible-area edges once per frame.
module sprite_motion #(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 24,
    parameter int SPRITE_X0  = 100,
    parameter int SPRITE_Y0  = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pixel_en,
    input  logic                  vsync_in,
    input  logic [2:0]            speed,
    output logic [HPOS_WIDTH-1:0] sx,
    output logic [VPOS_WIDTH-1:0] sy,
    output logic                  frame_tick
);

    import vga_pkg::*;

    localparam logic [HPOS_WIDTH:0]   X_LIM = (HPOS_WIDTH+1)'(H_DISPLAY);
    localparam logic [HPOS_WIDTH:0]   X_SPR = (HPOS_WIDTH+1)'(SPRITE_W);
    localparam logic [HPOS_WIDTH-1:0] X_MAX = HPOS_WIDTH'(H_DISPLAY - SPRITE_W);
    localparam logic [VPOS_WIDTH:0]   Y_LIM = (VPOS_WIDTH+1)'(V_DISPLAY);
    localparam logic [VPOS_WIDTH:0]   Y_SPR = (VPOS_WIDTH+1)'(SPRITE_H);
    localparam logic [VPOS_WIDTH-1:0] Y_MAX = VPOS_WIDTH'(V_DISPLAY - SPRITE_H);

    dir_t                  dx, dy, dx_next, dy_next;
    logic [HPOS_WIDTH-1:0] sx_next;
    logic [VPOS_WIDTH-1:0] sy_next;
    logic                  vsync_prev;
    logic                  trigger;

    logic [HPOS_WIDTH-1:0] step_x;
    logic [VPOS_WIDTH-1:0] step_y;
    logic [HPOS_WIDTH:0]   sx_w, step_x_w;
    logic [VPOS_WIDTH:0]   sy_w, step_y_w;

    assign trigger  = pixel_en && vsync_prev && !vsync_in;

    assign step_x   = {{(HPOS_WIDTH-3){1'b0}}, speed};
    assign step_y   = {{(VPOS_WIDTH-3){1'b0}}, speed};
    assign sx_w     = {1'b0, sx};
    assign sy_w     = {1'b0, sy};
    assign step_x_w = {1'b0, step_x};
    assign step_y_w = {1'b0, step_y};

    always_comb begin
        sx_next = sx;
        dx_next = dx;
        if (dx == DIR_POS) begin
            if (sx_w + X_SPR + step_x_w > X_LIM) begin
                sx_next = X_MAX;
                dx_next = DIR_NEG;
            end else begin
                sx_next = sx + step_x;
            end
        end else if (sx_w < step_x_w) begin
            sx_next = '0;
            dx_next = DIR_POS;
        end else begin
            sx_next = sx - step_x;
        end
    end

    always_comb begin
        sy_next = sy;
        dy_next = dy;
        if (dy == DIR_POS) begin
            if (sy_w + Y_SPR + step_y_w > Y_LIM) begin
                sy_next = Y_MAX;
                dy_next = DIR_NEG;
            end else begin
                sy_next = sy + step_y;
            end
        end else if (sy_w < step_y_w) begin
            sy_next = '0;
            dy_next = DIR_POS;
        end else begin
            sy_next = sy - step_y;
        end
    end

    // frame_tick sits outside the pixel_en gate so it is exactly one clk wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            sx         <= HPOS_WIDTH'(SPRITE_X0);
            sy         <= VPOS_WIDTH'(SPRITE_Y0);
            dx         <= DIR_POS;
            dy         <= DIR_POS;
            vsync_prev <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= trigger;
            if (pixel_en) begin
                vsync_prev <= vsync_in;
            end
            if (trigger) begin
                sx <= sx_next;
                sy <= sy_next;
                dx <= dx_next;
                dy <= dy_next;
            end
        end
    end

endmodule

// File: rtl/vga_sprite_mixer.sv
// Two-stage pixel pipeline: procedural background with one bouncing sprite on top;
// syncs are delayed by the same two stages so they leave aligned with the colour.
module vga_sprite_mixer #(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 24,
    parameter int SPRITE_X0  = 100,
    parameter int SPRITE_Y0  = 50
) (
    input logic               clk,
    input logic               rst,
    vga_sprite_mixer_if.slave bus
);

    import vga_pkg::*;

    localparam logic [HPOS_WIDTH:0] X_SPR = (HPOS_WIDTH+1)'(SPRITE_W);
    localparam logic [VPOS_WIDTH:0] Y_SPR = (VPOS_WIDTH+1)'(SPRITE_H);

    logic [HPOS_WIDTH-1:0] sx;
    logic [VPOS_WIDTH-1:0] sy;

    sprite_motion #(
        .HPOS_WIDTH (HPOS_WIDTH),
        .VPOS_WIDTH (VPOS_WIDTH),
        .H_DISPLAY  (H_DISPLAY),
        .V_DISPLAY  (V_DISPLAY),
        .SPRITE_W   (SPRITE_W),
        .SPRITE_H   (SPRITE_H),
        .SPRITE_X0  (SPRITE_X0),
        .SPRITE_Y0  (SPRITE_Y0)
    ) u_motion (
        .clk        (clk),
        .rst        (rst),
        .pixel_en   (bus.pixel_en),
        .vsync_in   (bus.vsync_in),
        .speed      (bus.speed),
        .sx         (sx),
        .sy         (sy),
        .frame_tick (bus.frame_tick)
    );

    logic [HPOS_WIDTH:0] hpos_w, sx_w;
    logic [VPOS_WIDTH:0] vpos_w, sy_w;
    logic                in_spr;
    rgb_t                bg;

    assign hpos_w = {1'b0, bus.hpos};
    assign vpos_w = {1'b0, bus.vpos};
    assign sx_w   = {1'b0, sx};
    assign sy_w   = {1'b0, sy};

    assign in_spr = (hpos_w >= sx_w) && (hpos_w < sx_w + X_SPR) &&
                    (vpos_w >= sy_w) && (vpos_w < sy_w + Y_SPR);
    assign bg     = background(bus.hpos[7:4], bus.vpos[7:4]);

    logic hsync1, vsync1, disp1, in_spr1;
    rgb_t bg1;
    logic hsync2, vsync2;
    rgb_t rgb2;

    // NOTE: non-blocking assignments let stage 2 read the stage-1 values from
    // before this edge, which is what makes the two stages a real pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync1  <= 1'b1;
            vsync1  <= 1'b1;
            disp1   <= 1'b0;
            in_spr1 <= 1'b0;
            bg1     <= '0;
            hsync2  <= 1'b1;
            vsync2  <= 1'b1;
            rgb2    <= '0;
        end else if (bus.pixel_en) begin
            hsync1  <= bus.hsync_in;
            vsync1  <= bus.vsync_in;
            disp1   <= bus.display_on_in;
            in_spr1 <= in_spr;
            bg1     <= bg;
            hsync2  <= hsync1;
            vsync2  <= vsync1;
            rgb2    <= !disp1 ? '0 : (in_spr1 ? rgb_t'(bus.sprite_rgb) : bg1);
        end
    end

    assign bus.hsync = hsync2;
    assign bus.vsync = vsync2;
    assign bus.rgb   = rgb2;

endmodule
